// File: rtl/mini_src_control_unit.sv
`default_nettype none
// ============================================================================
// mini_src_control_unit : hardwired Mini SRC control sequencer (fetch, T3..T7
// execute steps, memory hold, halt). Optional feature macro: SINGLE_STEP_EN.
// Revision: 1.0
// ============================================================================
module mini_src_control_unit #(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] OPC_ADD  = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  input  logic        Stop,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_instruction_bits,
  output logic        Run
);

  localparam logic [2:0] c_fetch0  = 3'd0;
  localparam logic [2:0] c_fetch1  = 3'd1;
  localparam logic [2:0] c_fetch2  = 3'd2;
  localparam logic [2:0] c_exec    = 3'd3;
  localparam logic [2:0] c_memhold = 3'd4;
  localparam logic [2:0] c_halted  = 3'd5;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] c_pause   = 3'd6;
  localparam logic [2:0] c_next_instr = c_pause;
`else
  localparam logic [2:0] c_next_instr = c_fetch0;
`endif

  localparam logic [4:0] c_op_ld   = 5'd0;
  localparam logic [4:0] c_op_ldi  = 5'd1;
  localparam logic [4:0] c_op_st   = 5'd2;
  localparam logic [4:0] c_op_div  = 5'd15;
  localparam logic [4:0] c_op_mul  = 5'd16;
  localparam logic [4:0] c_op_neg  = 5'd17;
  localparam logic [4:0] c_op_not  = 5'd18;
  localparam logic [4:0] c_op_br   = 5'd19;
  localparam logic [4:0] c_op_jr   = 5'd20;
  localparam logic [4:0] c_op_jal  = 5'd21;
  localparam logic [4:0] c_op_in   = 5'd22;
  localparam logic [4:0] c_op_out  = 5'd23;
  localparam logic [4:0] c_op_mfhi = 5'd24;
  localparam logic [4:0] c_op_mflo = 5'd25;
  localparam logic [4:0] c_op_halt = 5'd27;

  localparam bit         c_has_wait  = (MEM_WAIT > 0);
  localparam logic [2:0] c_hold_init = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  logic [2:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  logic [4:0] w_op;
  logic       w_is_alu3, w_is_imm, w_mem_step;
  logic [2:0] w_last_step, w_boundary;
  logic       w_unused_ir;

  assign w_op        = IR_Data[31:27];
  assign w_unused_ir = &{1'b0, IR_Data[26:0]};
  assign w_is_alu3   = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_is_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
  assign w_mem_step  = ((w_op == c_op_ld) && (step_q == 3'd6)) ||
                       ((w_op == c_op_st) && (step_q == 3'd7));
  assign w_boundary  = Stop ? c_halted : c_next_instr;
  assign Run         = run_q;

  always_comb begin
    case (w_op)
      c_op_ld, c_op_st:             w_last_step = 3'd7;
      c_op_div, c_op_mul, c_op_br:  w_last_step = 3'd6;
      c_op_ldi:                     w_last_step = 3'd5;
      c_op_neg, c_op_not, c_op_jal: w_last_step = 3'd4;
      default:                      w_last_step = (w_is_alu3 || w_is_imm) ? 3'd5 : 3'd3;
    endcase
  end

  // MEMHOLD reuses step_q to remember its caller: 0 = fetch, 6 = ld read, 7 = st write.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (run_q) begin
      case (state_q)
        c_fetch0: begin
          state_d = c_fetch1;
          step_d  = 3'd0;
        end
        c_fetch1: begin
          if (c_has_wait) begin
            state_d = c_memhold;
            cnt_d   = c_hold_init;
          end else begin
            state_d = c_fetch2;
          end
        end
        c_fetch2: begin
          state_d = c_exec;
          step_d  = 3'd3;
        end
        c_exec: begin
          if (c_has_wait && w_mem_step) begin
            state_d = c_memhold;
            cnt_d   = c_hold_init;
          end else if (w_op == c_op_halt) begin
            state_d = c_halted;
          end else if (step_q == w_last_step) begin
            state_d = w_boundary;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        c_memhold: begin
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else if (step_q == 3'd0) begin
            state_d = c_fetch2;
          end else if (step_q == 3'd6) begin
            state_d = c_exec;
            step_d  = 3'd7;
          end else begin
            state_d = w_boundary;
          end
        end
        c_halted: state_d = c_halted;
`ifdef SINGLE_STEP_EN
        c_pause: begin
          if (Stop) state_d = c_halted;
          else if (Step) state_d = c_fetch0;
        end
`endif
        default: state_d = c_fetch0;
      endcase
    end
    run_d = (state_d != c_halted);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= c_fetch0;
      step_q  <= 3'd0;
      cnt_q   <= 3'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    PC_in = 1'b0;      IR_in = 1'b0;     Y_in = 1'b0;       Z_in = 1'b0;
    HI_in = 1'b0;      LO_in = 1'b0;     MAR_in = 1'b0;     MDR_in = 1'b0;
    OutPort_in = 1'b0; IncPC = 1'b0;     PC_out = 1'b0;     Zhigh_out = 1'b0;
    Zlow_out = 1'b0;   HI_out = 1'b0;    LO_out = 1'b0;     MDR_out = 1'b0;
    InPort_out = 1'b0; C_out = 1'b0;     Gra = 1'b0;        Grb = 1'b0;
    Grc = 1'b0;        Rin = 1'b0;       Rout = 1'b0;       BAout = 1'b0;
    Read = 1'b0;       Write = 1'b0;     alu_instruction_bits = 5'd0;
    if (run_q) begin
      case (state_q)
        c_fetch0:  begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
        c_fetch1:  begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
        c_fetch2:  begin MDR_out = 1'b1; IR_in = 1'b1; end
        c_memhold: begin
          if (step_q == 3'd7) Write = 1'b1;
          else begin Read = 1'b1; MDR_in = 1'b1; end
        end
        c_exec: begin
          if (w_is_alu3 || w_is_imm) begin
            case (step_q)
              3'd3: begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
              3'd4: begin
                Grc = w_is_alu3; Rout = w_is_alu3; C_out = w_is_imm;
                alu_instruction_bits = w_op; Z_in = 1'b1;
              end
              default: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            endcase
          end else begin
            case (w_op)
              c_op_ld, c_op_ldi, c_op_st: begin
                case (step_q)
                  3'd3: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
                  3'd4: begin C_out = 1'b1; alu_instruction_bits = OPC_ADD; Z_in = 1'b1; end
                  3'd5: begin
                    Zlow_out = 1'b1;
                    if (w_op == c_op_ldi) begin Gra = 1'b1; Rin = 1'b1; end
                    else MAR_in = 1'b1;
                  end
                  3'd6: begin
                    MDR_in = 1'b1;
                    if (w_op == c_op_ld) Read = 1'b1;
                    else begin Gra = 1'b1; Rout = 1'b1; end
                  end
                  default: begin
                    if (w_op == c_op_ld) begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    else Write = 1'b1;
                  end
                endcase
              end
              c_op_div, c_op_mul: begin
                case (step_q)
                  3'd3: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                  3'd4: begin Grb = 1'b1; Rout = 1'b1; alu_instruction_bits = w_op; Z_in = 1'b1; end
                  3'd5: begin Zlow_out = 1'b1; LO_in = 1'b1; end
                  default: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
                endcase
              end
              c_op_neg, c_op_not: begin
                if (step_q == 3'd3) begin
                  Grb = 1'b1; Rout = 1'b1; alu_instruction_bits = w_op; Z_in = 1'b1;
                end else begin
                  Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
              end
              c_op_br: begin
                case (step_q)
                  3'd3: begin Gra = 1'b1; Rout = 1'b1; end
                  3'd4: begin PC_out = 1'b1; Y_in = 1'b1; end
                  3'd5: begin C_out = 1'b1; alu_instruction_bits = OPC_ADD; Z_in = 1'b1; end
                  default: begin Zlow_out = 1'b1; PC_in = CON_out; end
                endcase
              end
              c_op_jr: begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
              c_op_jal: begin
                if (step_q == 3'd3) begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                else begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
              end
              c_op_in:   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              c_op_out:  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
              c_op_mfhi: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              c_op_mflo: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
